// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for a single shared 32-bit ALU.
// One registered operand stage (EXEC) feeds a one-deep result buffer per requester.
module alu_share_arb #(
  parameter int DW        = 32,
  parameter int FIRST_REQ = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  input  logic [2:0]    req0_op_i,
  output logic          resp0_valid_o,
  input  logic          resp0_ready_i,
  output logic [DW-1:0] resp0_result_o,
  output logic          resp0_zero_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  input  logic [2:0]    req1_op_i,
  output logic          resp1_valid_o,
  input  logic          resp1_ready_i,
  output logic [DW-1:0] resp1_result_o,
  output logic          resp1_zero_o,
  output logic          busy_o
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  localparam logic LAST_RST = (FIRST_REQ == 0) ? 1'b1 : 1'b0;

  state_e        state_q;
  logic          busy_q;
  logic          last_q;
  logic          own_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    op_q;
  logic          resp0_valid_q;
  logic [DW-1:0] resp0_result_q;
  logic          resp0_zero_q;
  logic          resp1_valid_q;
  logic [DW-1:0] resp1_result_q;
  logic          resp1_zero_q;

  logic          elig0_s;
  logic          elig1_s;
  logic          grant0_s;
  logic          grant1_s;
  logic [DW-1:0] alu_res_d;
  logic          alu_zero_d;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [2:0]    op);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = {{(DW-1){1'b0}}, (a < b)};
      default: r = {DW{1'b0}};
    endcase
    return r;
  endfunction

  // Eligibility and round-robin grant; a full result buffer removes its owner from contention.
  always_comb begin
    elig0_s  = req0_valid_i & ~resp0_valid_q;
    elig1_s  = req1_valid_i & ~resp1_valid_q;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == IDLE) begin
      grant0_s = elig0_s & (~elig1_s | last_q);
      grant1_s = elig1_s & (~elig0_s | ~last_q);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Shared ALU evaluated from the operand register.
  always_comb begin
    alu_res_d  = alu_f(a_q, b_q, op_q);
    alu_zero_d = ~|alu_res_d;
  end

  // Arbitration FSM, operand register and per-requester result buffers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      last_q         <= LAST_RST;
      own_q          <= 1'b0;
      a_q            <= {DW{1'b0}};
      b_q            <= {DW{1'b0}};
      op_q           <= 3'b000;
      resp0_valid_q  <= 1'b0;
      resp0_result_q <= {DW{1'b0}};
      resp0_zero_q   <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp1_result_q <= {DW{1'b0}};
      resp1_zero_q   <= 1'b0;
    end else begin
      if (resp0_valid_q && resp0_ready_i) begin
        resp0_valid_q <= 1'b0;
      end
      if (resp1_valid_q && resp1_ready_i) begin
        resp1_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            state_q <= EXEC;
            busy_q  <= 1'b1;
            a_q     <= grant1_s ? req1_a_i  : req0_a_i;
            b_q     <= grant1_s ? req1_b_i  : req0_b_i;
            op_q    <= grant1_s ? req1_op_i : req0_op_i;
            own_q   <= grant1_s;
            last_q  <= grant1_s;
          end
        end
        EXEC: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          // The owner's buffer was empty at grant and only fills here, so no pop can collide.
          if (own_q) begin
            resp1_valid_q  <= 1'b1;
            resp1_result_q <= alu_res_d;
            resp1_zero_q   <= alu_zero_d;
          end else begin
            resp0_valid_q  <= 1'b1;
            resp0_result_q <= alu_res_d;
            resp0_zero_q   <= alu_zero_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready_o   = grant0_s;
  assign req1_ready_o   = grant1_s;
  assign resp0_valid_o  = resp0_valid_q;
  assign resp0_result_o = resp0_result_q;
  assign resp0_zero_o   = resp0_zero_q;
  assign resp1_valid_o  = resp1_valid_q;
  assign resp1_result_o = resp1_result_q;
  assign resp1_zero_o   = resp1_zero_q;
  assign busy_o         = busy_q;

endmodule
